// File: rtl/fft_pkg.sv
// Shared constants and helpers for the FFT input stage.
package fft_pkg;
  localparam int IN_ELEMENT_LENGTH_DEF = 8;
  localparam int N_POINTS_DEF          = 32;
  localparam int IDX_W                 = $clog2(N_POINTS_DEF);
  localparam int BITREV_MAX_W          = 16;

  // Reverse the low w bits of idx; bits above w come back zero.
  function automatic logic [BITREV_MAX_W-1:0] bitrev(input logic [BITREV_MAX_W-1:0] idx,
                                                     input int w);
    logic [BITREV_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < BITREV_MAX_W; i++)
      if (i < w) r[w-1-i] = idx[i];
    return r;
  endfunction
endpackage

// File: rtl/fft_frame_bank.sv
// One frame bank: N slots of W bits, single write port, whole bank read out packed.
module fft_frame_bank #(
  parameter int W = 8,
  parameter int N = 32
) (
  input  logic                 clk2,
  input  logic                 rst_n,
  input  logic                 i_we,
  input  logic [$clog2(N)-1:0] i_slot,
  input  logic [W-1:0]         i_data,
  output logic [N*W-1:0]       o_data
);
  logic [N-1:0][W-1:0] r_mem;

  always_ff @(posedge clk2 or negedge rst_n) begin
    if (!rst_n)    r_mem <= '0;
    else if (i_we) r_mem[i_slot] <= i_data;
  end

  assign o_data = r_mem;
endmodule

// File: rtl/fft_frame_loader.sv
// Serial-to-parallel frame loader: ping-pong banks filled from a sample stream,
// each finished frame offered as one packed word.
module fft_frame_loader
  import fft_pkg::*;
#(
  parameter int IN_ELEMENT_LENGTH = IN_ELEMENT_LENGTH_DEF,
  parameter int N_POINTS          = N_POINTS_DEF,
  parameter int BIT_REVERSE       = 1
) (
  input  logic                            clk2,
  input  logic                            rst_n,
  input  logic                            flush,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [IN_ELEMENT_LENGTH-1:0]    s_data,
  input  logic                            s_last,
  output logic                            frame_valid,
  input  logic                            frame_ready,
  output logic [N_POINTS*IN_ELEMENT_LENGTH-1:0] frame_data,
  output logic                            err
);
  localparam int W  = IN_ELEMENT_LENGTH;
  localparam int IW = $clog2(N_POINTS);
  localparam int FW = N_POINTS * W;

  logic [1:0]          r_full;
  logic                r_wr_bank;
  logic                r_rd_bank;
  logic                r_err;
  logic [IW-1:0]       r_wr_idx;

  logic                w_acc;
  logic                w_last_slot;
  logic                w_early;
  logic                w_store;
  logic                w_done;
  logic                w_drain;
  logic [IW-1:0]       w_slot;
  logic [1:0]          w_we;
  logic [1:0]          w_full_nxt;
  logic [1:0][FW-1:0]  w_bank_data;

  assign s_ready     = !r_full[r_wr_bank] && !flush;
  assign w_acc       = s_valid && s_ready;
  assign w_last_slot = (r_wr_idx == IW'(N_POINTS - 1));
  // s_last before the final slot drops the partial frame; that sample is not stored.
  assign w_early     = w_acc && s_last && !w_last_slot;
  assign w_store     = w_acc && !w_early;
  assign w_done      = w_store && w_last_slot;
  assign w_drain     = frame_valid && frame_ready && !flush;
  assign w_slot      = (BIT_REVERSE != 0) ? IW'(bitrev(BITREV_MAX_W'(r_wr_idx), IW)) : r_wr_idx;

  genvar b;
  generate
    for (b = 0; b < 2; b++) begin : g_bank
      assign w_we[b] = w_store && (r_wr_bank == 1'(b));
      fft_frame_bank #(.W(W), .N(N_POINTS)) u_bank (
        .clk2   (clk2),
        .rst_n  (rst_n),
        .i_we   (w_we[b]),
        .i_slot (w_slot),
        .i_data (s_data),
        .o_data (w_bank_data[b])
      );
    end
  endgenerate

  // Completion always targets the empty write bank and drain the full read bank,
  // so both can land in the same cycle without touching the same flag.
  always_comb begin
    w_full_nxt = r_full;
    if (w_drain) w_full_nxt[r_rd_bank] = 1'b0;
    if (w_done)  w_full_nxt[r_wr_bank] = 1'b1;
  end

  always_ff @(posedge clk2 or negedge rst_n) begin
    if (!rst_n) begin
      r_full    <= '0;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_wr_idx  <= '0;
      r_err     <= 1'b0;
    end else if (flush) begin
      r_full    <= '0;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_wr_idx  <= '0;
      r_err     <= 1'b0;
    end else begin
      r_full <= w_full_nxt;
      r_err  <= w_early || (w_done && !s_last);
      if (w_drain) r_rd_bank <= ~r_rd_bank;
      if (w_done)  r_wr_bank <= ~r_wr_bank;
      if (w_early)      r_wr_idx <= '0;
      else if (w_store) r_wr_idx <= r_wr_idx + 1'b1;
    end
  end

  assign frame_valid = r_full[r_rd_bank];
  assign frame_data  = w_bank_data[r_rd_bank];
  assign err         = r_err;
endmodule

// File: tb/tb_fft_frame_loader.sv
// Scoreboarded bench: bit-reversed and natural-order loaders share one stimulus stream.
module tb_fft_frame_loader;
  localparam int W  = 8;
  localparam int N  = 32;
  localparam int FW = N * W;

  logic          clk2 = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_last = 1'b0;
  logic          frame_ready = 1'b0;
  logic [W-1:0]  s_data = '0;
  logic          s_ready_br, s_ready_nat, fv_br, fv_nat, err_br, err_nat;
  logic [FW-1:0] fd_br, fd_nat;

  int total = 0;
  int bad = 0;
  int err_seen = 0;
  logic [FW-1:0] q_br[$];
  logic [FW-1:0] q_nat[$];

  always #5 clk2 = ~clk2;

  fft_frame_loader #(.IN_ELEMENT_LENGTH(W), .N_POINTS(N), .BIT_REVERSE(1)) dut (
    .clk2(clk2), .rst_n(rst_n), .flush(flush), .s_valid(s_valid), .s_ready(s_ready_br),
    .s_data(s_data), .s_last(s_last), .frame_valid(fv_br), .frame_ready(frame_ready),
    .frame_data(fd_br), .err(err_br));

  fft_frame_loader #(.IN_ELEMENT_LENGTH(W), .N_POINTS(N), .BIT_REVERSE(0)) dut_nat (
    .clk2(clk2), .rst_n(rst_n), .flush(flush), .s_valid(s_valid), .s_ready(s_ready_nat),
    .s_data(s_data), .s_last(s_last), .frame_valid(fv_nat), .frame_ready(frame_ready),
    .frame_data(fd_nat), .err(err_nat));

  task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic int rev5(input int k);
    int r = 0;
    for (int i = 0; i < 5; i++) if (k[i]) r |= (1 << (4 - i));
    return r;
  endfunction

  // Sample k of a frame carries value base+k (mod 2^W).
  function automatic logic [FW-1:0] mkframe(input int base, input bit br);
    logic [FW-1:0] f = '0;
    for (int k = 0; k < N; k++) f[(br ? rev5(k) : k)*W +: W] = W'(base + k);
    return f;
  endfunction

  task automatic push(input int base);
    q_br.push_back(mkframe(base, 1'b1));
    q_nat.push_back(mkframe(base, 1'b0));
  endtask

  // Monitor: compare every consumed frame against the queue head.
  always @(negedge clk2) begin
    if (err_br) err_seen++;
    if (rst_n && !flush && frame_ready) begin
      if (fv_br) begin
        if (q_br.size() == 0) chk("unexpected_frame_br", FW'(fv_br), '0);
        else chk("frame_br", fd_br, q_br.pop_front());
      end
      if (fv_nat) begin
        if (q_nat.size() == 0) chk("unexpected_frame_nat", FW'(fv_nat), '0);
        else chk("frame_nat", fd_nat, q_nat.pop_front());
      end
    end
  end

  // Offer one sample; returns #1 after the edge that accepted it.
  task automatic send(input logic [W-1:0] d, input bit last);
    s_valid = 1'b1; s_data = d; s_last = last;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk2);
      if (s_ready_br) begin
        @(posedge clk2); #1;
        s_valid = 1'b0; s_last = 1'b0;
        return;
      end
    end
    total++; bad++;
    $display("FAIL send_timeout: sample %0d never accepted within 200 cycles", d);
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic send_frame(input int base, input bit with_last);
    for (int k = 0; k < N; k++) send(W'(base + k), with_last && (k == N - 1));
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk2);
    #1;
  endtask

  initial begin
    int e0;
    #1;
    chk("reset_fv", FW'(fv_br), '0);
    chk("reset_fd", fd_br, '0);
    chk("reset_err", FW'(err_br), '0);
    chk("reset_s_ready", FW'(s_ready_br), FW'(1));
    cycles(1);
    rst_n = 1'b1;

    // Bit-reversed / natural load with immediate drain.
    frame_ready = 1'b1;
    push(0);
    for (int k = 0; k < N - 1; k++) send(W'(k), 1'b0);
    chk("fv_before_last", FW'(fv_br), '0);
    send(W'(31), 1'b1);
    chk("fv_after_last", FW'(fv_br), FW'(1));
    chk("br_slot1", FW'(fd_br[1*W +: W]), FW'(16));
    chk("br_slot2", FW'(fd_br[2*W +: W]), FW'(8));
    chk("br_slot31", FW'(fd_br[31*W +: W]), FW'(31));
    chk("nat_slot5", FW'(fd_nat[5*W +: W]), FW'(5));
    chk("no_err_good_frame", FW'(err_br), '0);
    cycles(2);

    // Back-pressure: two frames fill both banks, third stalls.
    frame_ready = 1'b0;
    push(32); push(64); push(96);
    send_frame(32, 1'b1);
    send_frame(64, 1'b1);
    chk("bp_s_ready_low", FW'(s_ready_br), '0);
    s_valid = 1'b1; s_data = W'(96); s_last = 1'b0;
    cycles(4);
    chk("bp_still_stalled", FW'(s_ready_br), '0);
    chk("bp_hold_fd", fd_br, mkframe(32, 1'b1));
    frame_ready = 1'b1;
    cycles(1);
    chk("bp_s_ready_back", FW'(s_ready_br), FW'(1));
    send_frame(96, 1'b1);
    cycles(3);

    // Early s_last on sample 10.
    e0 = err_seen;
    for (int k = 0; k < 10; k++) send(W'(200 + k), 1'b0);
    send(W'(210), 1'b1);
    chk("early_err_pulse", FW'(err_br), FW'(1));
    chk("early_err_nat", FW'(err_nat), FW'(1));
    cycles(1);
    chk("early_err_done", FW'(err_br), '0);
    chk("early_err_once", FW'(err_seen - e0), FW'(1));
    chk("early_no_fv", FW'(fv_br), '0);
    push(40);
    send_frame(40, 1'b1);
    cycles(2);

    // Missing s_last: frame still completes, err flags it.
    push(150);
    send_frame(150, 1'b0);
    chk("missing_last_err", FW'(err_br), FW'(1));
    chk("missing_last_fv", FW'(fv_br), FW'(1));
    cycles(2);

    // Reset mid-frame.
    for (int k = 0; k < 20; k++) send(W'(7 + k), 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_fv", FW'(fv_br), '0);
    chk("midrst_fd", fd_br, '0);
    chk("midrst_err", FW'(err_br), '0);
    chk("midrst_s_ready", FW'(s_ready_br), FW'(1));
    cycles(1);
    rst_n = 1'b1;
    push(60);
    send_frame(60, 1'b1);
    cycles(2);

    // Flush collides with a frame_ready handshake.
    frame_ready = 1'b0;
    send_frame(90, 1'b1);
    chk("pre_flush_fv", FW'(fv_br), FW'(1));
    flush = 1'b1; frame_ready = 1'b1;
    cycles(1);
    chk("flush_fv", FW'(fv_br), '0);
    flush = 1'b0;
    #1;
    chk("flush_s_ready", FW'(s_ready_br), FW'(1));
    push(5);
    send_frame(5, 1'b1);
    cycles(3);

    chk("q_br_empty", FW'(q_br.size()), '0);
    chk("q_nat_empty", FW'(q_nat.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
